// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: queues aligned fetch requests, issues them to the
// instruction memory bus under a response credit limit, returns in-order instruction pairs.
module inst_fetch_responder #(
    parameter int unsigned P_REQ_DEPTH = 4,
    parameter int unsigned P_RSP_DEPTH = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    input  logic        iFETCH_REQ,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oFETCH_LOCK,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_LOCK,
    input  logic        iMEM_VALID,
    input  logic [63:0] iMEM_DATA,
    input  logic [5:0]  iMEM_MMU_FLAGS,
    output logic        oINST_0_VALID,
    output logic [31:0] oINST_0,
    output logic [5:0]  oINST_0_MMU_FLAGS,
    output logic        oINST_1_VALID,
    output logic [31:0] oINST_1,
    output logic [5:0]  oINST_1_MMU_FLAGS,
    input  logic        iINST_LOCK
);

    localparam int unsigned REQ_AW = $clog2(P_REQ_DEPTH);
    localparam int unsigned REQ_CW = REQ_AW + 1;
    localparam int unsigned RSP_AW = $clog2(P_RSP_DEPTH);
    localparam int unsigned RSP_CW = RSP_AW + 1;
    localparam int unsigned SUM_W  = RSP_CW + 1;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  flags;
    } rsp_t;

    logic [28:0]       req_mem [P_REQ_DEPTH];
    logic [REQ_AW-1:0] req_wp, req_rp;
    logic [REQ_CW-1:0] req_cnt;

    rsp_t              rsp_mem [P_RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wp, rsp_rp;
    logic [RSP_CW-1:0] rsp_cnt;

    logic [RSP_CW-1:0] out_cnt;
    logic [RSP_CW-1:0] drop_cnt;

    logic        inst_valid;
    logic [63:0] inst_data;
    logic [5:0]  inst_flags;

    logic req_full, req_empty, rsp_empty;
    logic accept, credit_ok, mem_req_c, take;
    logic rsp_valid_ok, rsp_keep, out_pop_ok, bypass, rsp_push, rsp_pop, out_load;
    rsp_t rsp_in, load_src;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^iFETCH_ADDR[2:0];

    // Request side: accept, credit-limited issue
    assign req_full  = (req_cnt == REQ_CW'(P_REQ_DEPTH));
    assign req_empty = (req_cnt == '0);
    assign accept    = iFETCH_REQ && !req_full && !iFLUSH;
    assign credit_ok = (SUM_W'(out_cnt) + SUM_W'(rsp_cnt)) < SUM_W'(P_RSP_DEPTH);
    assign mem_req_c = !req_empty && credit_ok && !iFLUSH;
    assign take      = mem_req_c && !iMEM_LOCK;

    assign oFETCH_LOCK = req_full;
    assign oMEM_REQ    = mem_req_c;
    assign oMEM_ADDR   = req_empty ? 32'h0 : {req_mem[req_rp], 3'b000};

    // Response side: replies go straight to the output stage when nothing is queued ahead
    assign rsp_in       = '{data: iMEM_DATA, flags: iMEM_MMU_FLAGS};
    assign rsp_empty    = (rsp_cnt == '0);
    assign rsp_valid_ok = iMEM_VALID && (out_cnt != '0);
    assign rsp_keep     = rsp_valid_ok && (drop_cnt == '0) && !iFLUSH;
    assign out_pop_ok   = !iINST_LOCK && !iFLUSH;
    assign bypass       = out_pop_ok && rsp_empty && rsp_keep;
    assign rsp_push     = rsp_keep && !bypass;
    assign rsp_pop      = out_pop_ok && !rsp_empty;
    assign out_load     = out_pop_ok && (!rsp_empty || rsp_keep);
    assign load_src     = rsp_empty ? rsp_in : rsp_mem[rsp_rp];

    always_ff @(posedge iCLOCK) begin
        if (accept) req_mem[req_wp] <= iFETCH_ADDR[31:3];
        if (rsp_push) rsp_mem[rsp_wp] <= rsp_in;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            req_wp  <= '0;
            req_rp  <= '0;
            req_cnt <= '0;
        end else if (iFLUSH) begin
            req_wp  <= '0;
            req_rp  <= '0;
            req_cnt <= '0;
        end else begin
            if (accept) req_wp <= req_wp + REQ_AW'(1);
            if (take)   req_rp <= req_rp + REQ_AW'(1);
            req_cnt <= req_cnt + REQ_CW'(accept) - REQ_CW'(take);
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else if (iFLUSH) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wp <= rsp_wp + RSP_AW'(1);
            if (rsp_pop)  rsp_rp <= rsp_rp + RSP_AW'(1);
            rsp_cnt <= rsp_cnt + RSP_CW'(rsp_push) - RSP_CW'(rsp_pop);
        end
    end

    // Outstanding reads include those already marked for discard
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + RSP_CW'(take) - RSP_CW'(rsp_valid_ok);
            if (iFLUSH)
                drop_cnt <= out_cnt - RSP_CW'(rsp_valid_ok);
            else if (rsp_valid_ok && (drop_cnt != '0))
                drop_cnt <= drop_cnt - RSP_CW'(1);
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_flags <= '0;
        end else if (iFLUSH) begin
            inst_valid <= 1'b0;
        end else if (!iINST_LOCK) begin
            if (out_load) begin
                inst_valid <= 1'b1;
                inst_data  <= load_src.data;
                inst_flags <= load_src.flags;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

    assign oINST_0_VALID     = inst_valid;
    assign oINST_1_VALID     = inst_valid;
    assign oINST_0           = inst_data[31:0];
    assign oINST_1           = inst_data[63:32];
    assign oINST_0_MMU_FLAGS = inst_flags;
    assign oINST_1_MMU_FLAGS = inst_flags;

endmodule
